// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: queues one record per retired instruction in a
// first-word-fall-through FIFO and drains it over a valid/ready stream.
// Also keeps cycle/retire/drop counters and signals completion after halt.
module retire_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_retire_valid,
    input  logic             i_retire_trap,
    input  logic             i_retire_halt,
    input  logic [31:0]      i_retire_inst,
    input  logic [31:0]      i_retire_pc,
    input  logic [4:0]       i_retire_rd_waddr,
    input  logic [31:0]      i_retire_rd_wdata,
    output logic             o_rec_valid,
    input  logic             i_rec_ready,
    output logic [31:0]      o_rec_pc,
    output logic [31:0]      o_rec_inst,
    output logic [4:0]       o_rec_rd_waddr,
    output logic [31:0]      o_rec_rd_wdata,
    output logic             o_rec_trap,
    output logic             o_rec_halt,
    output logic [LW-1:0]    o_level,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_drop_count,
    output logic [CNT_W-1:0] o_retire_count,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic             o_done
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        trap;
        logic        halt;
    } rec_t;

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_DONE} state_t;

    state_t        state, next_state;
    rec_t          mem [DEPTH];
    rec_t          new_rec, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, pop, take, push, drop;
    logic          in_run, done_next;

    assign full  = (o_level == LW'(DEPTH));
    assign empty = (o_level == '0);
    assign pop   = o_rec_valid & i_rec_ready;
    // A retire is only considered while running; after halt it is ignored.
    assign take  = in_run & i_retire_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = take & (~full | pop);
    assign drop  = take & full & ~pop;

    // Record as stored; rd data is meaningless without a destination, so zero it.
    always_comb begin
        new_rec       = '0;
        new_rec.pc    = i_retire_pc;
        new_rec.inst  = i_retire_inst;
        new_rec.rd    = i_retire_rd_waddr;
        new_rec.wdata = (i_retire_rd_waddr == 5'd0) ? 32'd0 : i_retire_rd_wdata;
        new_rec.trap  = i_retire_trap;
        new_rec.halt  = i_retire_halt;
    end

    // FSM state register plus the registered completion flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_RUN;
            o_done <= 1'b0;
        end else begin
            state  <= next_state;
            o_done <= done_next;
        end
    end

    // FSM next state: a pushed or dropped halt record ends the run.
    always_comb begin
        next_state = state;
        case (state)
            S_RUN:    if (take && i_retire_halt) next_state = S_HALTED;
            S_HALTED: if (empty) next_state = S_DONE;
            default:  next_state = state;
        endcase
    end

    // FSM outputs: run qualifier and the value o_done takes on the next edge.
    always_comb begin
        in_run    = (state == S_RUN);
        done_next = (next_state == S_DONE);
    end

    // Storage write; contents need no reset since validity comes from o_level.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= new_rec;
    end

    // Pointers and occupancy; full/empty are derived from the level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      o_level <= o_level + LW'(1);
            else if (pop && !push) o_level <= o_level - LW'(1);
        end
    end

    // Statistics counters; all wrap, overflow flag is sticky.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycle_count  <= '0;
            o_retire_count <= '0;
            o_drop_count   <= '0;
            o_overflow     <= 1'b0;
        end else begin
            if (in_run) o_cycle_count  <= o_cycle_count + CNT_W'(1);
            if (push)   o_retire_count <= o_retire_count + CNT_W'(1);
            if (drop) begin
                o_drop_count <= o_drop_count + CNT_W'(1);
                o_overflow   <= 1'b1;
            end
        end
    end

    // Head record shown straight from storage; zeroed while empty so a
    // reset never exposes stale contents.
    always_comb begin
        o_rec_valid    = ~empty;
        head           = empty ? '0 : mem[rd_ptr];
        o_rec_pc       = head.pc;
        o_rec_inst     = head.inst;
        o_rec_rd_waddr = head.rd;
        o_rec_rd_wdata = head.wdata;
        o_rec_trap     = head.trap;
        o_rec_halt     = head.halt;
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: ordering, overflow, full-with-pop,
// halt/done sequencing, async reset and a backpressure scoreboard run.
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b1;
    logic             i_retire_valid = 1'b0;
    logic             i_retire_trap = 1'b0;
    logic             i_retire_halt = 1'b0;
    logic [31:0]      i_retire_inst = '0;
    logic [31:0]      i_retire_pc = '0;
    logic [4:0]       i_retire_rd_waddr = '0;
    logic [31:0]      i_retire_rd_wdata = '0;
    logic             o_rec_valid;
    logic             i_rec_ready = 1'b0;
    logic [31:0]      o_rec_pc, o_rec_inst, o_rec_rd_wdata;
    logic [4:0]       o_rec_rd_waddr;
    logic             o_rec_trap, o_rec_halt;
    logic [LW-1:0]    o_level;
    logic             o_overflow;
    logic [CNT_W-1:0] o_drop_count, o_retire_count, o_cycle_count;
    logic             o_done;

    int n_vec = 0;
    int n_err = 0;

    retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_retire_valid(i_retire_valid), .i_retire_trap(i_retire_trap),
        .i_retire_halt(i_retire_halt), .i_retire_inst(i_retire_inst),
        .i_retire_pc(i_retire_pc), .i_retire_rd_waddr(i_retire_rd_waddr),
        .i_retire_rd_wdata(i_retire_rd_wdata),
        .o_rec_valid(o_rec_valid), .i_rec_ready(i_rec_ready),
        .o_rec_pc(o_rec_pc), .o_rec_inst(o_rec_inst),
        .o_rec_rd_waddr(o_rec_rd_waddr), .o_rec_rd_wdata(o_rec_rd_wdata),
        .o_rec_trap(o_rec_trap), .o_rec_halt(o_rec_halt),
        .o_level(o_level), .o_overflow(o_overflow),
        .o_drop_count(o_drop_count), .o_retire_count(o_retire_count),
        .o_cycle_count(o_cycle_count), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] wd, input logic halt);
        i_retire_valid    = v;
        i_retire_pc       = pc;
        i_retire_inst     = pc ^ 32'hA5A5_0000;
        i_retire_rd_waddr = rd;
        i_retire_rd_wdata = wd;
        i_retire_trap     = pc[2];
        i_retire_halt     = halt;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b0);
        i_rec_ready = 1'b0;
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // Scoreboard fields derived from a sequence number.
    function automatic logic [31:0] sb_pc(input int n);
        return 32'h1000 + 32'(n) * 4;
    endfunction

    int q[$];
    int issued, drops, accepted, cyc;
    logic pop_m, push_m, stall;
    logic [31:0] held_pc, epc;
    logic [4:0]  erd;

    initial begin
        // Async reset with no clock edge involved.
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_rec_valid), 0);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_cnts", o_cycle_count | o_retire_count | o_drop_count, 0);
        chk("rst_flags", {30'd0, o_overflow, o_done}, 0);
        tick();
        i_rst_n = 1'b1;

        // Three retires in order with ready high; one-cycle latency, no bypass.
        do_reset();
        i_rec_ready = 1'b1;
        drive(1'b1, 32'h0, 5'd3, 32'h11, 1'b0);
        #1 chk("nobypass", 32'(o_rec_valid), 0);
        tick();
        chk("a0_valid", 32'(o_rec_valid), 1);
        chk("a0_pc", o_rec_pc, 32'h0);
        chk("a0_wdata", o_rec_rd_wdata, 32'h11);
        drive(1'b1, 32'h4, 5'd0, 32'hDEAD, 1'b0);
        tick();
        chk("a1_pc", o_rec_pc, 32'h4);
        chk("a1_rd0_wdata", o_rec_rd_wdata, 32'h0);
        chk("a1_trap", 32'(o_rec_trap), 1);
        drive(1'b1, 32'h8, 5'd7, 32'h77, 1'b0);
        tick();
        chk("a2_pc", o_rec_pc, 32'h8);
        chk("a2_inst", o_rec_inst, 32'hA5A5_0008);
        chk("a2_rd", 32'(o_rec_rd_waddr), 7);
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
        chk("a_empty", 32'(o_rec_valid), 0);
        chk("a_retire_cnt", o_retire_count, 3);

        // Overflow: 20 retires into a stalled sink.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(i) * 4, 5'd1, 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        chk("ovf_level", 32'(o_level), 16);
        chk("ovf_drops", o_drop_count, 4);
        chk("ovf_flag", 32'(o_overflow), 1);
        chk("ovf_retired", o_retire_count, 16);
        chk("ovf_head", o_rec_pc, 32'h0);

        // Full with simultaneous pop and push.
        drive(1'b1, 32'h100, 5'd2, 32'h5, 1'b0);
        i_rec_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        chk("fp_level", 32'(o_level), 16);
        chk("fp_drops", o_drop_count, 4);
        chk("fp_retired", o_retire_count, 17);
        for (int i = 1; i < 16; i++) begin
            chk("drain_pc", o_rec_pc, 32'(i) * 4);
            tick();
        end
        chk("drain_last", o_rec_pc, 32'h100);
        tick();
        chk("drain_empty", 32'(o_level), 0);
        chk("ovf_sticky", 32'(o_overflow), 1);

        // Halt in the 10th run cycle, then ignored retires, then drain to done.
        do_reset();
        repeat (9) tick();
        drive(1'b1, 32'h40, 5'd0, 32'h0, 1'b1);
        tick();
        chk("h_cycle", o_cycle_count, 10);
        chk("h_rec_halt", 32'(o_rec_halt), 1);
        drive(1'b1, 32'h44, 5'd1, 32'h1, 1'b0);
        repeat (3) tick();
        chk("h_cycle_frozen", o_cycle_count, 10);
        chk("h_ignored_level", 32'(o_level), 1);
        chk("h_ignored_cnt", o_retire_count, 1);
        chk("h_not_done", 32'(o_done), 0);
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        i_rec_ready = 1'b1;
        tick();
        chk("h_popped", 32'(o_level), 0);
        chk("h_done_wait", 32'(o_done), 0);
        tick();
        chk("h_done", 32'(o_done), 1);
        repeat (2) tick();
        chk("h_done_hold", 32'(o_done), 1);

        // Backpressure scoreboard.
        do_reset();
        issued = 0; drops = 0; accepted = 0; cyc = 0;
        while ((issued < 200 || q.size() > 0) && cyc < 5000) begin
            cyc++;
            i_rec_ready = 1'($urandom_range(0, 1));
            if (issued < 200 && $urandom_range(0, 9) < 6)
                drive(1'b1, sb_pc(issued), 5'(issued), 32'(issued) * 3, 1'b0);
            else
                drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
            #1;
            chk("bp_valid", 32'(o_rec_valid), 32'(q.size() > 0));
            pop_m  = (q.size() > 0) && i_rec_ready;
            push_m = i_retire_valid && (q.size() < DEPTH || pop_m);
            stall  = o_rec_valid && !i_rec_ready;
            held_pc = o_rec_pc;
            if (pop_m) begin
                epc = sb_pc(q[0]);
                erd = 5'(q[0]);
                chk("bp_pc", o_rec_pc, epc);
                chk("bp_wdata", o_rec_rd_wdata, (erd == 5'd0) ? 32'd0 : 32'(q[0]) * 3);
            end
            if (i_retire_valid) begin
                issued++;
                if (!push_m) drops++;
            end
            tick();
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                q.push_back(issued - 1);
                accepted++;
            end
            if (stall) chk("bp_hold", o_rec_pc, held_pc);
        end
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        chk("bp_timeout", 32'(q.size()), 0);
        chk("bp_retired", o_retire_count, 32'(accepted));
        chk("bp_drops", o_drop_count, 32'(drops));
        chk("bp_level", 32'(o_level), 0);

        // Reset mid-drain, asserted between edges.
        i_rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i) * 4 + 32'h200, 5'd1, 32'd1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        chk("mr_pre_level", 32'(o_level), 5);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(o_rec_valid), 0);
        chk("mr_level", 32'(o_level), 0);
        chk("mr_pc", o_rec_pc, 0);
        chk("mr_cnt", o_retire_count, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("mr_after", 32'(o_rec_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
